// File: rtl/display_timing.sv
// Raster timing generator: screen coordinates, line/frame strobes and VGA
// sync/data-enable delayed to line up with the renderers' pixel output.
module display_timing #(
    parameter int   COORD_W    = 10,
    parameter int   H_RES      = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_RES      = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic H_POL      = 1'b0,
    parameter logic V_POL      = 1'b0,
    parameter int   PIPE_DELAY = 2,
    parameter int   FCNT_W     = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic [COORD_W-1:0] sx_o,
    output logic [COORD_W-1:0] sy_o,
    output logic               line_o,
    output logic               frame_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o,
    output logic [FCNT_W-1:0]  frame_cnt_o
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_RES);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_RES + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_RES + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_RES + V_FP + V_SYNC - 1);

    logic [COORD_W-1:0] sx_r;
    logic [COORD_W-1:0] sy_r;
    logic [COORD_W-1:0] sx_nxt_s;
    logic [COORD_W-1:0] sy_nxt_s;
    logic               line_r;
    logic               frame_r;
    logic               line_nxt_s;
    logic               frame_nxt_s;
    logic               hs_lvl_s;
    logic               vs_lvl_s;
    logic               de_raw_s;
    logic [PIPE_DELAY:0] hs_pipe_r;
    logic [PIPE_DELAY:0] vs_pipe_r;
    logic [PIPE_DELAY:0] de_pipe_r;
    logic [FCNT_W-1:0]  frame_cnt_r;
    logic               first_seen_r;

    // Next raster position: sx wraps every line, sy steps only on an sx wrap.
    always_comb begin
        sx_nxt_s = sx_r;
        sy_nxt_s = sy_r;
        if (sx_r == H_LAST) begin
            sx_nxt_s = '0;
            if (sy_r == V_LAST) begin
                sy_nxt_s = '0;
            end else begin
                sy_nxt_s = sy_r + COORD_W'(1);
            end
        end else begin
            sx_nxt_s = sx_r + COORD_W'(1);
        end
    end

    // Strobes and raw video signals are derived from the next position so the
    // registered result lines up with sx_o/sy_o; sync levels carry polarity.
    always_comb begin
        line_nxt_s  = (sx_nxt_s == '0);
        frame_nxt_s = (sx_nxt_s == '0) && (sy_nxt_s == '0);
        de_raw_s    = (sx_nxt_s < H_ACT) && (sy_nxt_s < V_ACT);
        if ((sx_nxt_s >= HS_START) && (sx_nxt_s <= HS_END)) begin
            hs_lvl_s = H_POL;
        end else begin
            hs_lvl_s = ~H_POL;
        end
        if ((sy_nxt_s >= VS_START) && (sy_nxt_s <= VS_END)) begin
            vs_lvl_s = V_POL;
        end else begin
            vs_lvl_s = ~V_POL;
        end
    end

    // Coordinate counters and aligned strobes.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            sx_r    <= H_LAST;
            sy_r    <= V_LAST;
            line_r  <= 1'b0;
            frame_r <= 1'b0;
        end else begin
            sx_r    <= sx_nxt_s;
            sy_r    <= sy_nxt_s;
            line_r  <= line_nxt_s;
            frame_r <= frame_nxt_s;
        end
    end

    // Sync/enable delay line; stage 0 is coincident with the coordinates and
    // reset clears every stage at once so blanking is immediate.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            hs_pipe_r <= {(PIPE_DELAY + 1){~H_POL}};
            vs_pipe_r <= {(PIPE_DELAY + 1){~V_POL}};
            de_pipe_r <= '0;
        end else begin
            hs_pipe_r[0] <= hs_lvl_s;
            vs_pipe_r[0] <= vs_lvl_s;
            de_pipe_r[0] <= de_raw_s;
            for (int i = 1; i <= PIPE_DELAY; i++) begin
                hs_pipe_r[i] <= hs_pipe_r[i-1];
                vs_pipe_r[i] <= vs_pipe_r[i-1];
                de_pipe_r[i] <= de_pipe_r[i-1];
            end
        end
    end

    // Completed-frame counter: the first frame start after reset only arms it.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            frame_cnt_r  <= '0;
            first_seen_r <= 1'b0;
        end else if (frame_nxt_s) begin
            if (first_seen_r) begin
                frame_cnt_r <= frame_cnt_r + FCNT_W'(1);
            end
            first_seen_r <= 1'b1;
        end
    end

    assign sx_o        = sx_r;
    assign sy_o        = sy_r;
    assign line_o      = line_r;
    assign frame_o     = frame_r;
    assign hsync_o     = hs_pipe_r[PIPE_DELAY];
    assign vsync_o     = vs_pipe_r[PIPE_DELAY];
    assign de_o        = de_pipe_r[PIPE_DELAY];
    assign frame_cnt_o = frame_cnt_r;

endmodule

// File: tb/tb_display_timing.sv
// Bench for display_timing: one full-size 640x480 instance plus two small-raster
// instances (delay 3 / 2-bit counter, and delay 0 / positive polarity).
module tb_display_timing;

    // small raster: 25 clocks per line, 15 lines per frame
    localparam int S_HR = 16, S_HF = 2, S_HS = 4, S_HB = 3;
    localparam int S_VR = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_HT = S_HR + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VR + S_VF + S_VS + S_VB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_s;

    logic [9:0]  a_sx, a_sy;
    logic        a_line, a_frame, a_hs, a_vs, a_de;
    logic [15:0] a_cnt;
    logic [4:0]  b_sx, b_sy;
    logic        b_line, b_frame, b_hs, b_vs, b_de;
    logic [1:0]  b_cnt;
    logic [4:0]  c_sx, c_sy;
    logic        c_line, c_frame, c_hs, c_vs, c_de;
    logic [3:0]  c_cnt;

    display_timing dut_a (
        .clk_i(clk), .reset_i(rst_a), .sx_o(a_sx), .sy_o(a_sy), .line_o(a_line),
        .frame_o(a_frame), .hsync_o(a_hs), .vsync_o(a_vs), .de_o(a_de), .frame_cnt_o(a_cnt)
    );

    display_timing #(
        .COORD_W(5), .H_RES(S_HR), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_RES(S_VR), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .PIPE_DELAY(3), .FCNT_W(2)
    ) dut_b (
        .clk_i(clk), .reset_i(rst_s), .sx_o(b_sx), .sy_o(b_sy), .line_o(b_line),
        .frame_o(b_frame), .hsync_o(b_hs), .vsync_o(b_vs), .de_o(b_de), .frame_cnt_o(b_cnt)
    );

    display_timing #(
        .COORD_W(5), .H_RES(S_HR), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_RES(S_VR), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(0), .FCNT_W(4)
    ) dut_c (
        .clk_i(clk), .reset_i(rst_s), .sx_o(c_sx), .sy_o(c_sy), .line_o(c_line),
        .frame_o(c_frame), .hsync_o(c_hs), .vsync_o(c_vs), .de_o(c_de), .frame_cnt_o(c_cnt)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    int a_x, a_y, a_n, s_x, s_y, b_n, c_n;
    bit a_first, s_first, a_ln, a_fr, s_ln, s_fr;
    logic [2:0] qa[$];
    logic [2:0] qb[$];
    logic [2:0] qc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // {hsync active, vsync active, data enable} for a raster position
    function automatic logic [2:0] raw(input int x, input int y, input int hr, input int hf,
                                       input int hs, input int vr, input int vf, input int vs);
        logic h, v, d;
        h = (x >= hr + hf) && (x <= hr + hf + hs - 1);
        v = (y >= vr + vf) && (y <= vr + vf + vs - 1);
        d = (x < hr) && (y < vr);
        return {h, v, d};
    endfunction

    function automatic logic lvl(input logic act, input logic pol);
        return act ? pol : ~pol;
    endfunction

    // one clock: advance the models, then check every output of every instance
    task automatic tick();
        logic [2:0] ea, eb, ec;
        @(posedge clk);
        if (!rst_a) begin
            a_x = 799; a_y = 524; a_n = 0; a_first = 0; a_ln = 0; a_fr = 0;
            qa.delete();
            repeat (2) qa.push_back(3'b000);
            ea = 3'b000;
        end else begin
            if (a_x == 799) begin
                a_x = 0;
                a_y = (a_y == 524) ? 0 : a_y + 1;
            end else begin
                a_x = a_x + 1;
            end
            a_ln = (a_x == 0);
            a_fr = (a_x == 0) && (a_y == 0);
            if (a_fr) begin
                if (a_first) a_n = (a_n + 1) % 65536;
                a_first = 1;
            end
            qa.push_back(raw(a_x, a_y, 640, 16, 96, 480, 10, 2));
            ea = qa.pop_front();
        end
        if (!rst_s) begin
            s_x = S_HT - 1; s_y = S_VT - 1; b_n = 0; c_n = 0; s_first = 0; s_ln = 0; s_fr = 0;
            qb.delete();
            qc.delete();
            repeat (3) qb.push_back(3'b000);
            eb = 3'b000;
            ec = 3'b000;
        end else begin
            if (s_x == S_HT - 1) begin
                s_x = 0;
                s_y = (s_y == S_VT - 1) ? 0 : s_y + 1;
            end else begin
                s_x = s_x + 1;
            end
            s_ln = (s_x == 0);
            s_fr = (s_x == 0) && (s_y == 0);
            if (s_fr) begin
                if (s_first) begin
                    b_n = (b_n + 1) % 4;
                    c_n = (c_n + 1) % 16;
                end
                s_first = 1;
            end
            qb.push_back(raw(s_x, s_y, S_HR, S_HF, S_HS, S_VR, S_VF, S_VS));
            qc.push_back(raw(s_x, s_y, S_HR, S_HF, S_HS, S_VR, S_VF, S_VS));
            eb = qb.pop_front();
            ec = qc.pop_front();
        end
        #1;
        chk("a_sx", a_sx, a_x);         chk("a_sy", a_sy, a_y);
        chk("a_line", a_line, a_ln);    chk("a_frame", a_frame, a_fr);
        chk("a_hsync", a_hs, lvl(ea[2], 1'b0));
        chk("a_vsync", a_vs, lvl(ea[1], 1'b0));
        chk("a_de", a_de, ea[0]);       chk("a_cnt", a_cnt, a_n);
        chk("b_sx", b_sx, s_x);         chk("b_sy", b_sy, s_y);
        chk("b_line", b_line, s_ln);    chk("b_frame", b_frame, s_fr);
        chk("b_hsync", b_hs, lvl(eb[2], 1'b0));
        chk("b_vsync", b_vs, lvl(eb[1], 1'b0));
        chk("b_de", b_de, eb[0]);       chk("b_cnt", b_cnt, b_n);
        chk("c_sx", c_sx, s_x);         chk("c_sy", c_sy, s_y);
        chk("c_line", c_line, s_ln);    chk("c_frame", c_frame, s_fr);
        chk("c_hsync", c_hs, lvl(ec[2], 1'b1));
        chk("c_vsync", c_vs, lvl(ec[1], 1'b1));
        chk("c_de", c_de, ec[0]);       chk("c_cnt", c_cnt, c_n);
    endtask

    initial begin
        int line_hits, hs_low, hs_first, de_hi, de_first, wrap_seen;
        int fb_de, fb_vs, fb_fr, vs_fx, vs_fy, found;
        logic [9:0] prev_sx, prev_sy;
        logic [1:0] fcnt_q[$];
        logic [1:0] fcnt_exp[5];

        rst_a = 1'b0;
        rst_s = 1'b0;
        repeat (5) begin
            tick();
            chk("rst_sx", a_sx, 799);   chk("rst_sy", a_sy, 524);
            chk("rst_de", a_de, 0);     chk("rst_hs", a_hs, 1);
            chk("rst_vs", a_vs, 1);     chk("rst_line", a_line, 0);
            chk("rst_frame", a_frame, 0); chk("rst_cnt", a_cnt, 0);
        end

        rst_a = 1'b1;
        rst_s = 1'b1;
        tick();
        chk("rel_sx", a_sx, 0);   chk("rel_sy", a_sy, 0);
        chk("rel_line", a_line, 1); chk("rel_frame", a_frame, 1);
        chk("rel_cnt", a_cnt, 0);
        if (b_frame) fcnt_q.push_back(b_cnt);

        line_hits = 0; hs_low = 0; hs_first = -1; de_hi = 0; de_first = -1; wrap_seen = 0;
        fb_de = 0; fb_vs = 0; fb_fr = 0; vs_fx = -1; vs_fy = -1;
        for (int i = 0; i < 1600; i++) begin
            prev_sx = a_sx;
            prev_sy = a_sy;
            tick();
            if (a_line) line_hits++;
            if (a_line && a_sx != 0) line_hits = line_hits + 100;
            if (a_sx == 0 && a_sy == 1 && prev_sx == 799 && prev_sy == 0) wrap_seen++;
            if (a_sy == 0 && !a_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = a_sx;
            end
            if (a_sy == 0 && a_de) begin
                de_hi++;
                if (de_first < 0) de_first = a_sx;
            end
            if (b_frame) fcnt_q.push_back(b_cnt);
            if (i < S_HT * S_VT) begin
                if (b_de) fb_de++;
                if (b_frame) fb_fr++;
                if (!b_vs) begin
                    fb_vs++;
                    if (vs_fx < 0) begin
                        vs_fx = b_sx;
                        vs_fy = b_sy;
                    end
                end
            end
        end
        chk("line_hits", line_hits, 2);
        chk("line_wrap", wrap_seen, 1);
        chk("hs_low_len", hs_low, 96);
        chk("hs_first_sx", hs_first, 658);
        chk("de_line_len", de_hi, 640);
        chk("de_first_sx", de_first, 2);
        chk("frame_de", fb_de, S_HR * S_VR);
        chk("frame_vs_len", fb_vs, S_HT * S_VS);
        chk("frame_vs_sx", vs_fx, 3);
        chk("frame_vs_sy", vs_fy, S_VR + S_VF);
        chk("frame_pulses", fb_fr, 1);

        fcnt_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        chk("fcnt_pulses", fcnt_q.size(), 5);
        for (int k = 0; k < 5 && k < fcnt_q.size(); k++) chk("fcnt_seq", fcnt_q[k], fcnt_exp[k]);

        // mid-frame reset in active video
        found = 0;
        for (int i = 0; i < 2 * S_HT * S_VT; i++) begin
            if (b_sx == 10 && b_sy == 5) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("mid_found", found, 1);
        chk("mid_de_before", b_de, 1);
        rst_s = 1'b0;
        tick();
        chk("mid_sx", b_sx, S_HT - 1);
        chk("mid_sy", b_sy, S_VT - 1);
        chk("mid_de", b_de, 0);
        rst_s = 1'b1;
        tick();
        chk("restart_sx", b_sx, 0);
        chk("restart_sy", b_sy, 0);
        chk("restart_frame", b_frame, 1);
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
